// File: rtl/nanov_reg_sequencer.sv
// ---------------------------------------------------------------------------
// nanov_reg_sequencer
// Sequences the bit-serial register file for one XLEN-bit register operation
// at a time. It tracks the register file's free-running rotation, aligns each
// accepted op to bit 0 of a rotation, and drives the rs/rd addresses and the
// write strobes. A stalled op resumes only when the rotation comes back to the
// stalled bit. Back-to-back ops chain with no bubble by using read-through.
// Sits between the decoder/ALU control and nanoV_registers.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   op_valid/op_ready   op handshake
//   op_rs1/op_rs2/op_rd op register addresses
//   op_wr               op writes rd
//   stall               datapath cannot consume/produce the current bit
//   reg_rs1/rs2/rd      current op addresses to the register file
//   reg_next_rs1/rs2    source addresses one cycle ahead
//   reg_wr_en           write the current bit of rd
//   reg_wr_next_en      write the next bit of rd
//   reg_read_through    forward rd into the next op's first bit
//   bit_idx             bit being processed (valid while busy)
//   busy                an op is latched (ALIGN/RUN/PAUSE)
//   done                one-cycle pulse on the last processed bit
// ---------------------------------------------------------------------------
module nanov_reg_sequencer #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned REG_ADDR_BITS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        op_valid,
   output logic                        op_ready,
   input  logic [REG_ADDR_BITS-1:0]    op_rs1,
   input  logic [REG_ADDR_BITS-1:0]    op_rs2,
   input  logic [REG_ADDR_BITS-1:0]    op_rd,
   input  logic                        op_wr,
   input  logic                        stall,
   output logic [REG_ADDR_BITS-1:0]    reg_rs1,
   output logic [REG_ADDR_BITS-1:0]    reg_rs2,
   output logic [REG_ADDR_BITS-1:0]    reg_rd,
   output logic [REG_ADDR_BITS-1:0]    reg_next_rs1,
   output logic [REG_ADDR_BITS-1:0]    reg_next_rs2,
   output logic                        reg_wr_en,
   output logic                        reg_wr_next_en,
   output logic                        reg_read_through,
   output logic [$clog2(XLEN)-1:0]     bit_idx,
   output logic                        busy,
   output logic                        done
);

   localparam int unsigned IDX_W = $clog2(XLEN);
   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(XLEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALIGN = 2'd1,
      S_RUN   = 2'd2,
      S_PAUSE = 2'd3
   } state_t;

   state_t                     state;
   logic [IDX_W-1:0]           rot;
   logic [IDX_W-1:0]           idx_q;
   logic [REG_ADDR_BITS-1:0]   cur_rs1;
   logic [REG_ADDR_BITS-1:0]   cur_rs2;
   logic [REG_ADDR_BITS-1:0]   cur_rd;
   logic                       cur_wr;

   logic                       run_live;
   logic                       last_bit;
   logic                       rot_last;
   logic                       accept;
   logic                       wr_active;
   logic [IDX_W-1:0]           rot_next;
   logic [IDX_W-1:0]           idx_prev;

   // Rotation successor and the rotation value one before the held bit.
   assign rot_next = (rot == LAST_BIT) ? '0 : rot + IDX_W'(1);
   assign idx_prev = (idx_q == '0) ? LAST_BIT : idx_q - IDX_W'(1);
   assign rot_last = (rot == LAST_BIT);

   // A bit is processed only in RUN with the datapath ready; reset kills it.
   assign run_live  = (state == S_RUN) && !stall && !rst;
   assign last_bit  = (idx_q == LAST_BIT);
   assign wr_active = cur_wr && (cur_rd != '0);

   assign done      = run_live && last_bit;
   assign op_ready  = !rst && ((state == S_IDLE) || done);
   assign accept    = op_valid && op_ready;

   // Write strobes; rd==0 is never written.
   assign reg_wr_en        = run_live && wr_active;
   assign reg_wr_next_en   = run_live && wr_active && !last_bit;
   assign reg_read_through = done && accept && wr_active;

   // On a chaining cycle the regfile must already see the next op's sources.
   assign reg_next_rs1 = (done && accept) ? op_rs1 : cur_rs1;
   assign reg_next_rs2 = (done && accept) ? op_rs2 : cur_rs2;

   assign reg_rs1 = cur_rs1;
   assign reg_rs2 = cur_rs2;
   assign reg_rd  = cur_rd;
   assign bit_idx = idx_q;
   assign busy    = (state != S_IDLE);

   // Sequencer state, rotation tracking and op latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         rot     <= '0;
         idx_q   <= '0;
         cur_rs1 <= '0;
         cur_rs2 <= '0;
         cur_rd  <= '0;
         cur_wr  <= 1'b0;
      end else begin
         rot <= rot_next;
         if (accept) begin
            cur_rs1 <= op_rs1;
            cur_rs2 <= op_rs2;
            cur_rd  <= op_rd;
            cur_wr  <= op_wr;
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  idx_q <= '0;
                  // Bit 0 is presented next cycle only if the rotation wraps now.
                  state <= rot_last ? S_RUN : S_ALIGN;
               end
            end
            S_ALIGN: begin
               if (rot_last) state <= S_RUN;
            end
            S_RUN: begin
               if (stall) begin
                  state <= S_PAUSE;
               end else if (last_bit) begin
                  idx_q <= '0;
                  state <= accept ? S_RUN : S_IDLE;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            S_PAUSE: begin
               // Resume only when the held bit comes round again.
               if (!stall && (rot == idx_prev)) state <= S_RUN;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nanov_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nanov_reg_sequencer
// Directed bench for nanov_reg_sequencer. Inputs are driven at the falling
// edge, outputs sampled 1ns later; trot mirrors the rotation the DUT should
// be presenting in the current cycle.
// ---------------------------------------------------------------------------
module tb_nanov_reg_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       op_valid = 1'b0;
   logic       op_ready;
   logic [3:0] op_rs1 = '0, op_rs2 = '0, op_rd = '0;
   logic       op_wr = 1'b0;
   logic       stall = 1'b0;
   logic [3:0] reg_rs1, reg_rs2, reg_rd, reg_next_rs1, reg_next_rs2;
   logic       reg_wr_en, reg_wr_next_en, reg_read_through;
   logic [4:0] bit_idx;
   logic       busy, done;

   int n_cmp = 0;
   int n_err = 0;
   int trot  = 0;
   int cyc   = 0;
   int c0, c1, acnt;

   nanov_reg_sequencer #(.XLEN(32), .REG_ADDR_BITS(4)) dut (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_rs1(op_rs1), .op_rs2(op_rs2), .op_rd(op_rd), .op_wr(op_wr),
      .stall(stall),
      .reg_rs1(reg_rs1), .reg_rs2(reg_rs2), .reg_rd(reg_rd),
      .reg_next_rs1(reg_next_rs1), .reg_next_rs2(reg_next_rs2),
      .reg_wr_en(reg_wr_en), .reg_wr_next_en(reg_wr_next_en),
      .reg_read_through(reg_read_through),
      .bit_idx(bit_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
      trot = (trot + 1) % 32;
      cyc++;
   endtask

   // Present an op at the current cycle, then advance to the cycle with bit 0.
   task automatic start_op(input string tag, input logic [3:0] rs1, input logic [3:0] rs2,
                           input logic [3:0] rd, input logic wr, output int align_cnt);
      int bad = 0;
      op_valid = 1'b1; op_rs1 = rs1; op_rs2 = rs2; op_rd = rd; op_wr = wr;
      #1 check_eq({tag, "_ready"}, 32'(op_ready), 32'd1);
      next_cycle();
      op_valid = 1'b0;
      align_cnt = 0;
      while (trot != 0) begin
         #1 if (busy !== 1'b1 || reg_wr_en !== 1'b0 || op_ready !== 1'b0) bad++;
         align_cnt++;
         next_cycle();
      end
      check_eq({tag, "_align"}, 32'(bad), 32'd0);
   endtask

   // Check bits first..stop; caller has already advanced into bit 'first'.
   task automatic run_bits(input string tag, input int first, input int stop, input logic exp_wr);
      int bad = 0;
      for (int b = first; b <= stop; b++) begin
         if (b != first) next_cycle();
         #1;
         if (bit_idx !== 5'(b) || busy !== 1'b1 ||
             reg_wr_en !== exp_wr || reg_wr_next_en !== (exp_wr && b != 31) ||
             done !== (b == 31) || op_ready !== (b == 31)) bad++;
      end
      check_eq({tag, "_run"}, 32'(bad), 32'd0);
   endtask

   task automatic check_idle(input string tag);
      next_cycle();
      #1;
      check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_idle_rdy"},  32'(op_ready), 32'd1);
      check_eq({tag, "_idle_strb"}, {30'd0, reg_wr_en, done}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst = 1'b1;
      next_cycle();
      rst = 1'b0; trot = 0;
      #1;
      check_eq("rst_ready", 32'(op_ready), 32'd1);
      check_eq("rst_busy",  32'(busy), 32'd0);
      check_eq("rst_outs",  {reg_rs1, reg_rs2, reg_rd, 3'(0), reg_wr_en, reg_wr_next_en, done, bit_idx},
               32'd0);

      // 1: accept at rot 5, align 26 cycles, write all 32 bits
      repeat (5) next_cycle();
      start_op("t1", 4'd1, 4'd2, 4'd3, 1'b1, acnt);
      check_eq("t1_align_cnt", 32'(acnt), 32'd26);
      c0 = cyc;
      run_bits("t1", 0, 31, 1'b1);
      check_eq("t1_done_lat", 32'(cyc - c0), 32'd31);
      check_eq("t1_rt_noacc", 32'(reg_read_through), 32'd0);
      check_eq("t1_nrs1", 32'(reg_next_rs1), 32'd1);
      check_idle("t1");

      // 2: chain op B (rs1=3) onto op A (rd=3) with read-through
      start_op("t2a", 4'd5, 4'd7, 4'd3, 1'b1, acnt);
      run_bits("t2a", 0, 30, 1'b1);
      next_cycle();
      op_valid = 1'b1; op_rs1 = 4'd3; op_rs2 = 4'd4; op_rd = 4'd6; op_wr = 1'b1;
      #1;
      check_eq("t2_done", 32'(done), 32'd1);
      check_eq("t2_rt",   32'(reg_read_through), 32'd1);
      check_eq("t2_nrs1", 32'(reg_next_rs1), 32'd3);
      check_eq("t2_nrs2", 32'(reg_next_rs2), 32'd4);
      check_eq("t2_rs1",  32'(reg_rs1), 32'd5);
      next_cycle();
      op_valid = 1'b0;
      #1;
      check_eq("t2_b0_idx", 32'(bit_idx), 32'd0);
      check_eq("t2_b0_addr", {20'd0, reg_rs1, reg_rs2, reg_rd}, {20'd0, 4'd3, 4'd4, 4'd6});
      check_eq("t2_b0_wr", {30'd0, busy, reg_wr_en}, 32'd3);
      next_cycle();
      run_bits("t2b", 1, 31, 1'b1);
      check_idle("t2");

      // 3: stall three cycles at bit 10, resume a rotation later
      start_op("t3", 4'd1, 4'd1, 4'd2, 1'b1, acnt);
      c0 = cyc;
      run_bits("t3a", 0, 9, 1'b1);
      next_cycle();
      stall = 1'b1;
      #1 check_eq("t3_stall_strb", {30'd0, reg_wr_en, done}, 32'd0);
      next_cycle();
      next_cycle();
      next_cycle();
      stall = 1'b0;
      begin
         int bad = 0;
         while (trot != 10) begin
            #1 if (busy !== 1'b1 || reg_wr_en !== 1'b0 || bit_idx !== 5'd10) bad++;
            next_cycle();
         end
         check_eq("t3_pause", 32'(bad), 32'd0);
      end
      run_bits("t3b", 10, 31, 1'b1);
      check_eq("t3_done_lat", 32'(cyc - c0), 32'd63);
      check_idle("t3");

      // 4: rd=0 with wr=1 runs full length without strobes
      start_op("t4", 4'd2, 4'd3, 4'd0, 1'b1, acnt);
      run_bits("t4", 0, 31, 1'b0);
      check_idle("t4");

      // 5: reset at bit 20 drops the op and restarts the rotation
      start_op("t5", 4'd2, 4'd3, 4'd3, 1'b1, acnt);
      run_bits("t5", 0, 19, 1'b1);
      next_cycle();
      rst = 1'b1;
      #1;
      check_eq("t5_rst_strb", {29'd0, reg_wr_en, reg_wr_next_en, done}, 32'd0);
      next_cycle();
      rst = 1'b0; trot = 0;
      #1;
      check_eq("t5_busy",  32'(busy), 32'd0);
      check_eq("t5_ready", 32'(op_ready), 32'd1);
      check_eq("t5_outs", {reg_rd, 1'b0, reg_wr_en, done, bit_idx}, 32'd0);
      start_op("t5r", 4'd1, 4'd2, 4'd9, 1'b1, acnt);
      check_eq("t5r_align_cnt", 32'(acnt), 32'd31);
      run_bits("t5r", 0, 31, 1'b1);
      check_idle("t5r");

      // 6: stall at bit 31 withholds done until the next rotation
      start_op("t6", 4'd1, 4'd2, 4'd5, 1'b1, acnt);
      run_bits("t6", 0, 30, 1'b1);
      next_cycle();
      stall = 1'b1;
      op_valid = 1'b1; op_rs1 = 4'd7; op_rs2 = 4'd8; op_rd = 4'd0; op_wr = 1'b0;
      #1;
      check_eq("t6_st_done",  32'(done), 32'd0);
      check_eq("t6_st_ready", 32'(op_ready), 32'd0);
      check_eq("t6_st_wr",    32'(reg_wr_en), 32'd0);
      next_cycle();
      stall = 1'b0;
      begin
         int bad = 0;
         while (trot != 31) begin
            #1 if (op_ready !== 1'b0 || done !== 1'b0 || reg_wr_en !== 1'b0) bad++;
            next_cycle();
         end
         check_eq("t6_pause", 32'(bad), 32'd0);
      end
      #1;
      check_eq("t6_done",  32'(done), 32'd1);
      check_eq("t6_ready", 32'(op_ready), 32'd1);
      check_eq("t6_wr",    {30'd0, reg_wr_en, reg_wr_next_en}, 32'd2);
      check_eq("t6_rt",    32'(reg_read_through), 32'd1);
      check_eq("t6_nrs1",  32'(reg_next_rs1), 32'd7);
      next_cycle();
      op_valid = 1'b0;
      #1;
      check_eq("t6_b0", {26'd0, busy, bit_idx}, {26'd0, 1'b1, 5'd0});
      check_eq("t6_b0_rd", 32'(reg_rd), 32'd0);
      next_cycle();
      run_bits("t6b", 1, 31, 1'b0);
      check_idle("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
